// File: rtl/hll_pkg.sv
// Shared defaults and types for the HLL harmonic-sum feeder.
// Widths here match the reciprocal stage that consumes sum_data.
package hll_pkg;

  localparam int HLL_P         = 14;
  localparam int HLL_RANK_W    = 6;
  localparam int HLL_SUM_W     = 32;
  localparam int HLL_FRAC_BITS = HLL_SUM_W - HLL_P - 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } hll_sum_state_t;

  typedef logic [HLL_RANK_W-1:0] rank_t;
  typedef logic [HLL_SUM_W-1:0]  sum_t;

endpackage

// File: rtl/hll_rank_term.sv
// First pipeline stage: turns a bucket rank into its 2^-rank term in
// UQ fixed point, plus an empty-bucket flag, both registered with valid.
module hll_rank_term
  import hll_pkg::*;
#(
  parameter int RANK_W    = HLL_RANK_W,
  parameter int SUM_W     = HLL_SUM_W,
  parameter int FRAC_BITS = HLL_FRAC_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RANK_W-1:0] rank,
  input  logic              rank_valid,
  output logic [SUM_W-1:0]  term,
  output logic              is_zero,
  output logic              term_valid
);

  logic [SUM_W-1:0] term_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    term_d = '0;
    // Ranks beyond the fractional precision contribute nothing by design.
    if (int'(rank) <= FRAC_BITS) begin
      term_d = SUM_W'(1) << (FRAC_BITS - int'(rank));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term       <= '0;
      is_zero    <= 1'b0;
      term_valid <= 1'b0;
    end else begin
      term       <= term_d;
      is_zero    <= (rank == '0);
      term_valid <= rank_valid;
    end
  end

endmodule

// File: rtl/hll_harmonic_sum.sv
// Streams one sketch of 2^P ranks, accumulates Z = sum(2^-rank) and the
// empty-bucket count, and hands Z to the reciprocal stage with a valid pulse.
module hll_harmonic_sum
  import hll_pkg::*;
#(
  parameter int P      = HLL_P,
  parameter int RANK_W = HLL_RANK_W,
  parameter int SUM_W  = HLL_SUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RANK_W-1:0] in_rank,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  sum_data,
  output logic              sum_valid,
  output logic [P:0]        zero_count,
  output logic              busy
);

  localparam int FRAC_BITS = SUM_W - P - 1;

  hll_sum_state_t   state_q, state_d;
  logic [P-1:0]     beat_cnt;
  logic [P:0]       zero_cnt;
  logic [SUM_W-1:0] acc;
  logic             drain_cnt;
  logic             frame_start;
  logic             accept;
  logic             last_beat;
  logic [SUM_W-1:0] term;
  logic             term_is_zero;
  logic             term_valid;

  hll_rank_term #(
    .RANK_W   (RANK_W),
    .SUM_W    (SUM_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_rank_term (
    .clk       (clk),
    .rst_n     (rst_n),
    .rank      (in_rank),
    .rank_valid(accept),
    .term      (term),
    .is_zero   (term_is_zero),
    .term_valid(term_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DRAIN;
      // Two cycles let the last term clear S1 and land in the accumulator.
      DRAIN:   if (drain_cnt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ACCUM);
    busy        = (state_q != IDLE);
    frame_start = (state_q == IDLE) && start;
    accept      = in_ready && in_valid;
    last_beat   = accept && (&beat_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      zero_cnt  <= '0;
      acc       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= (state_q == DRAIN) ? ~drain_cnt : 1'b0;
      if (frame_start) begin
        beat_cnt <= '0;
        zero_cnt <= '0;
        acc      <= '0;
      end else begin
        if (accept) beat_cnt <= beat_cnt + 1'b1;
        // Full-scale Z is exactly 2^(SUM_W-1), so acc cannot wrap.
        if (term_valid) begin
          acc      <= acc + term;
          zero_cnt <= zero_cnt + (P+1)'(term_is_zero);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_data   <= '0;
      zero_count <= '0;
      sum_valid  <= 1'b0;
    end else begin
      sum_valid <= (state_q == DONE);
      if (state_q == DONE) begin
        sum_data   <= acc;
        zero_count <= zero_cnt;
      end
    end
  end

endmodule

// File: tb/tb_hll_harmonic_sum.sv
// Directed bench for hll_harmonic_sum at P=4: a frame-level model predicts
// every output each cycle, and literal golden values pin each frame result.
module tb_hll_harmonic_sum;

  localparam int P         = 4;
  localparam int RANK_W    = 6;
  localparam int SUM_W     = 32;
  localparam int FRAC_BITS = SUM_W - P - 1;
  localparam int NBEATS    = 1 << P;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [RANK_W-1:0] in_rank = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SUM_W-1:0]  sum_data;
  logic              sum_valid;
  logic [P:0]        zero_count;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  hll_harmonic_sum #(.P(P), .RANK_W(RANK_W), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_rank   (in_rank),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_data  (sum_data),
    .sum_valid (sum_valid),
    .zero_count(zero_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint rank_term(input int r);
    if (r > FRAC_BITS) return 0;
    return longint'(1) << (FRAC_BITS - r);
  endfunction

  // Frame-level model: a frame opens on start when idle, takes 16 valid
  // beats, and the result appears 3 edges after the last accepted beat.
  bit          m_busy, m_open, m_pulse;
  int          m_beats, m_zeros, m_cd;
  longint      m_sum;
  logic [31:0] m_out_sum;
  logic [P:0]  m_out_zero;

  task automatic model_step();
    bit was_busy;
    if (!rst_n) begin
      m_busy = 0; m_open = 0; m_pulse = 0; m_beats = 0; m_zeros = 0;
      m_cd = 0; m_sum = 0; m_out_sum = '0; m_out_zero = '0;
      return;
    end
    was_busy = m_busy;
    m_pulse  = 0;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        m_pulse    = 1;
        m_out_sum  = 32'(m_sum);
        m_out_zero = (P+1)'(m_zeros);
        m_busy     = 0;
      end
    end
    if (!was_busy) begin
      if (start) begin
        m_busy = 1; m_open = 1; m_beats = 0; m_sum = 0; m_zeros = 0;
      end
    end else if (m_open && in_valid) begin
      m_beats++;
      m_sum += rank_term(int'(in_rank));
      if (in_rank == 0) m_zeros++;
      if (m_beats == NBEATS) begin
        m_open = 0;
        m_cd   = 3;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 64'(in_ready), 64'(m_open));
      check("busy", 64'(busy), 64'(m_busy));
      check("sum_valid", 64'(sum_valid), 64'(m_pulse));
      check("sum_data", 64'(sum_data), 64'(m_out_sum));
      check("zero_count", 64'(zero_count), 64'(m_out_zero));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int rank, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_rank  = RANK_W'(rank);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp_sum, input int exp_zero);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sum_valid && n < 20);
    check({name, "_pulse_seen"}, 64'(sum_valid), 64'(1));
    check({name, "_sum"}, 64'(sum_data), 64'(exp_sum));
    check({name, "_zeros"}, 64'(zero_count), 64'(exp_zero));
    @(negedge clk);
    check({name, "_single_pulse"}, 64'(sum_valid), 64'(0));
    tick();
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", 64'(sum_data), 64'(0));
    check("reset_valid", 64'(sum_valid), 64'(0));
    check("reset_ready", 64'(in_ready), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    tick();

    // 1: all empty buckets give full-scale Z.
    start_frame();
    for (int i = 0; i < NBEATS; i++) send_beat(0, 0);
    wait_result("all_zero", 32'h8000_0000, 16);

    // 2: all rank 1.
    start_frame();
    for (int i = 0; i < NBEATS; i++) send_beat(1, 0);
    wait_result("all_one", 32'h4000_0000, 0);

    // 3: half empty, half rank 30 which truncates to zero.
    start_frame();
    for (int i = 0; i < NBEATS; i++) send_beat((i < 8) ? 0 : 30, 0);
    wait_result("trunc", 32'h4000_0000, 8);

    // 4: ranks 0..15 with random gaps.
    start_frame();
    for (int i = 0; i < NBEATS; i++) send_beat(i, $urandom_range(0, 2));
    wait_result("ramp_gaps", 32'h0FFF_F000, 1);

    // 5: reset mid-frame discards it and clears outputs at once.
    start_frame();
    for (int i = 0; i < 7; i++) send_beat(3, 0);
    rst_n = 1'b0;
    #2;
    check("midreset_sum", 64'(sum_data), 64'(0));
    check("midreset_zeros", 64'(zero_count), 64'(0));
    check("midreset_ready", 64'(in_ready), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (sum_valid) seen = 1;
    end
    check("midreset_no_pulse", 64'(seen), 64'(0));
    tick();
    start_frame();
    for (int i = 0; i < NBEATS; i++) send_beat(0, 0);
    wait_result("after_reset", 32'h8000_0000, 16);

    // 6: beats in IDLE, a beat alongside start, and a mid-frame start are ignored.
    in_rank  = '0;
    in_valid = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < NBEATS; i++) begin
      if (i == 5) start = 1'b1;
      send_beat(2, 0);
      start = 1'b0;
    end
    in_rank  = '0;
    in_valid = 1'b1;
    wait_result("ignored", 32'h2000_0000, 0);
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
